// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode and FSM state encodings
// plus the bit positions of the {ill, dz, ovf, carry, zero} flag vector.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_CMP = 4'd7,
        OP_MUL = 4'd8,
        OP_DIV = 4'd9,
        OP_ILL = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_DZ    = 3;
    localparam int FLAG_ILL   = 4;
    localparam int NUM_FLAGS  = 5;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per
// cycle. Both share the {hi, lo} register pair, which is also the result.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  op_e                  op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CNTW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] hi, lo, opnd;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic             is_div;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic             div_ge;

    // The partial remainder stays below the divisor, so bit WIDTH of the
    // difference is a reliable "did not fit" indicator.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_shift = {hi, lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = ~div_diff[WIDTH];
        if (is_div) begin
            hi_n = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], div_ge};
        end else begin
            hi_n = mul_sum[WIDTH:1];
            lo_n = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset as well, so an aborted operation
        // leaves no stale operands or count behind.
        if (!reset) begin
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                hi     <= '0;
                lo     <= (op == OP_DIV) ? a : b;
                opnd   <= (op == OP_DIV) ? b : a;
                is_div <= (op == OP_DIV);
                cnt    <= CNTW'(WIDTH);
                busy   <= 1'b1;
            end else if (busy) begin
                hi  <= hi_n;
                lo  <= lo_n;
                cnt <= cnt - CNTW'(1);
                if (cnt == CNTW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign result = {hi, lo};

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: captures operands on accept, evaluates single-cycle ops
// locally and delegates MUL/DIV to alu_muldiv; result/flags land with done.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 active,
    input  logic [OPW-1:0]       instrucciones,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   result,
    output logic [4:0]           flags,
    output logic                 busy,
    output logic                 done
);

    localparam int SHW = $clog2(WIDTH);

    state_e               state;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [OPW-1:0]       op_q;
    logic                 launched;
    op_e                  op;
    logic                 use_md, md_start, md_busy, md_done, complete;
    logic [2*WIDTH-1:0]   md_result, res_n;
    logic [NUM_FLAGS-1:0] flags_n;
    logic [WIDTH:0]       add_w, sub_w, shl_w, shr_w;
    logic [SHW-1:0]       sh;

    always_comb op = (op_q < OPW'(10)) ? op_e'(op_q[3:0]) : OP_ILL;

    // First EXEC cycle launches the iterative unit; single-cycle ops finish on
    // the second so that every non-iterative op has the same latency.
    assign use_md   = (op == OP_MUL) || ((op == OP_DIV) && (b_q != '0));
    assign md_start = (state == ST_EXEC) && !launched && use_md && !md_busy;
    assign complete = (state == ST_EXEC) && launched && (use_md ? md_done : 1'b1);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .op     (op),
        .a      (a_q),
        .b      (b_q),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can infer a latch.
        res_n   = '0;
        flags_n = '0;
        add_w   = {1'b0, a_q} + {1'b0, b_q};
        sub_w   = {1'b0, a_q} - {1'b0, b_q};
        sh      = b_q[SHW-1:0];
        shl_w   = {1'b0, a_q} << sh;
        shr_w   = {a_q, 1'b0} >> sh;
        case (op)
            OP_ADD: begin
                res_n[WIDTH-1:0]   = add_w[WIDTH-1:0];
                flags_n[FLAG_CARRY] = add_w[WIDTH];
                flags_n[FLAG_OVF]   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                if (op == OP_SUB) res_n[WIDTH-1:0] = sub_w[WIDTH-1:0];
                flags_n[FLAG_CARRY] = sub_w[WIDTH];
                flags_n[FLAG_OVF]   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: res_n[WIDTH-1:0] = a_q & b_q;
            OP_OR:  res_n[WIDTH-1:0] = a_q | b_q;
            OP_XOR: res_n[WIDTH-1:0] = a_q ^ b_q;
            OP_SHL: begin
                res_n[WIDTH-1:0]    = shl_w[WIDTH-1:0];
                flags_n[FLAG_CARRY] = shl_w[WIDTH];
            end
            OP_SHR: begin
                res_n[WIDTH-1:0]    = shr_w[WIDTH:1];
                flags_n[FLAG_CARRY] = shr_w[0];
            end
            OP_MUL: res_n = md_result;
            OP_DIV: begin
                if (b_q == '0) begin
                    res_n            = {a_q, {WIDTH{1'b1}}};
                    flags_n[FLAG_DZ] = 1'b1;
                end else begin
                    res_n = md_result;
                end
            end
            default: flags_n[FLAG_ILL] = 1'b1;
        endcase
        if (op == OP_CMP)      flags_n[FLAG_ZERO] = (sub_w[WIDTH-1:0] == '0);
        else if (op != OP_ILL) flags_n[FLAG_ZERO] = (res_n == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            launched <= 1'b0;
            result   <= '0;
            flags    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (active) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= instrucciones;
                        launched <= 1'b0;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    launched <= 1'b1;
                    if (complete) begin
                        result <= res_n;
                        flags  <= flags_n;
                        state  <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8: expectations are computed from an
// arithmetic model at accept time and compared when done pulses.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, active;
    logic [3:0]  instrucciones;
    logic [7:0]  a, b;
    logic [15:0] result;
    logic [4:0]  flags;
    logic        busy, done;

    typedef struct {
        logic [15:0] res;
        logic [4:0]  fl;   // {ill, dz, ovf, carry, zero}
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    alu_seq #(.WIDTH(8), .OPW(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .active        (active),
        .instrucciones (instrucciones),
        .a             (a),
        .b             (b),
        .result        (result),
        .flags         (flags),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int   sx, sy, r, sh;
        e.res = 16'h0; e.fl = 5'h0; e.lat = 2; e.acc = 0;
        sx = x[7] ? int'(x) - 256 : int'(x);
        sy = y[7] ? int'(y) - 256 : int'(y);
        sh = int'(y) % 8;
        case (op)
            4'd0: begin
                r = int'(x) + int'(y);
                e.res = 16'(r & 255);
                e.fl[1] = (r > 255);
                e.fl[2] = (sx + sy > 127) || (sx + sy < -128);
            end
            4'd1, 4'd7: begin
                r = int'(x) - int'(y);
                if (op == 4'd1) e.res = 16'(r & 255);
                e.fl[1] = (x < y);
                e.fl[2] = (sx - sy > 127) || (sx - sy < -128);
            end
            4'd2: e.res = {8'h00, x & y};
            4'd3: e.res = {8'h00, x | y};
            4'd4: e.res = {8'h00, x ^ y};
            4'd5: begin
                e.res = 16'((int'(x) << sh) & 255);
                e.fl[1] = (sh != 0) && (((int'(x) >> (8 - sh)) & 1) != 0);
            end
            4'd6: begin
                e.res = 16'(int'(x) >> sh);
                e.fl[1] = (sh != 0) && (((int'(x) >> (sh - 1)) & 1) != 0);
            end
            4'd8: begin
                e.res = 16'(int'(x) * int'(y));
                e.lat = 10;
            end
            4'd9: begin
                if (y == 8'h00) begin
                    e.res = {x, 8'hFF};
                    e.fl[3] = 1'b1;
                end else begin
                    e.res = {8'(x % y), 8'(x / y)};
                    e.lat = 10;
                end
            end
            default: e.fl[4] = 1'b1;
        endcase
        if (op == 4'd7)      e.fl[0] = (((int'(x) - int'(y)) & 255) == 0);
        else if (op <= 4'd9) e.fl[0] = (e.res == 16'h0);
        return e;
    endfunction

    // Leaves the caller on a falling edge with the DUT idle.
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    task automatic push_exp(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        e = model(op, x, y);
        e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic start_op(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        wait_idle();
        instrucciones = op; a = x; b = y; active = 1'b1;
        @(posedge clk); #1;
        push_exp(op, x, y);
        @(negedge clk);
        active = 1'b0;
        a = 8'($urandom); b = 8'($urandom); instrucciones = 4'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", done, 0);
            end else begin
                m_e = sb.pop_front();
                check("result", result, m_e.res);
                check("flags", flags, m_e.fl);
                check("latency", cyc - m_e.acc, m_e.lat);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int r;
        reset = 1'b0; active = 1'b0; instrucciones = 4'h0; a = 8'h00; b = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        active = 1'b1; instrucciones = OP_ADD; a = 8'h11; b = 8'h22;
        @(negedge clk);
        check("rst_no_accept", busy, 0);
        active = 1'b0;
        reset = 1'b1;

        start_op(OP_ADD, 8'hFF, 8'h01);
        start_op(OP_SUB, 8'h80, 8'h01);
        start_op(OP_CMP, 8'h80, 8'h01);

        // A start request in the middle of a MUL must not disturb it.
        start_op(OP_MUL, 8'hFF, 8'hFF);
        repeat (3) @(negedge clk);
        check("mul_busy", busy, 1);
        active = 1'b1; instrucciones = OP_ADD; a = 8'h01; b = 8'h01;
        @(negedge clk);
        active = 1'b0;

        start_op(OP_DIV, 8'h64, 8'h07);
        start_op(OP_DIV, 8'h5A, 8'h00);
        start_op(4'hF, 8'h12, 8'h34);
        start_op(OP_AND, 8'h0F, 8'hF0);
        start_op(OP_SHL, 8'h81, 8'h01);
        start_op(OP_SHR, 8'h81, 8'h01);
        start_op(OP_SHL, 8'hA5, 8'h08);
        start_op(OP_XOR, 8'hAA, 8'hAA);
        start_op(OP_ADD, 8'h7F, 8'h01);
        wait_drain();

        // Hold active through the done cycle; no accept may happen there.
        wait_idle();
        instrucciones = OP_OR; a = 8'h03; b = 8'h04; active = 1'b1;
        @(posedge clk); #1;
        push_exp(OP_OR, 8'h03, 8'h04);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 10);
        @(negedge clk);
        check("done_cycle_ignored", busy, 0);
        active = 1'b0;
        wait_drain();

        repeat (24) begin
            r = int'($urandom_range(0, 10));
            if (r == 10) r = int'($urandom_range(10, 15));
            start_op(4'(r), 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom));
        end
        wait_drain();

        // Abort a MUL on its 4th EXEC cycle.
        start_op(OP_ADD, 8'h10, 8'h20);
        wait_drain();
        start_op(OP_MUL, 8'h0C, 8'h0D);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        check("abort_flags", flags, 0);
        check("abort_done", done, 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (14) @(negedge clk);
        start_op(OP_ADD, 8'h03, 8'h04);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal values 4..32, powers of two only.
REQ-002 Parameter OPW, default 4: opcode width in bits.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 active  input  1  start request; accepted only on an edge where active=1 and busy=0.
REQ-006 instrucciones  input  OPW  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 CMP, 8 MUL, 9 DIV; 10..15 are illegal.
REQ-007 a  input  WIDTH  operand A, unsigned; captured at accept.
REQ-008 b  input  WIDTH  operand B, unsigned; captured at accept.
REQ-009 result  output  2*WIDTH  registered result; holds its value until the next done.
REQ-010 flags  output  5  {ill, dz, ovf, carry, zero}; registered and updated together with result.
REQ-011 busy  output  1  high from the cycle after accept until the cycle done is high.
REQ-012 done  output  1  one-cycle pulse; result and flags are valid in the same cycle.

Function
REQ-013 The FSM SHALL have three states: IDLE, EXEC and DONE.
- IDLE -> EXEC on accept.
- EXEC -> DONE when the operation completes.
- DONE -> IDLE unconditionally.
REQ-014 Single-cycle ops (opcodes 0-7, illegal opcodes, DIV by zero): done SHALL assert 2 cycles after the accept edge.
REQ-015 MUL and DIV with b!=0: done SHALL assert exactly WIDTH+2 cycles after the accept edge.
REQ-016 While busy=1, active SHALL be ignored and the captured a, b and opcode SHALL NOT change.
REQ-017 Within the DONE cycle, active SHALL be ignored; the earliest next accept is the cycle after done.
REQ-018 Result width rule:
- ops 0-6: result[WIDTH-1:0] carries the value and result[2W-1:W] = 0.
- MUL: result is the full 2W-bit unsigned product.
- DIV: result = {remainder, quotient}.
REQ-019 ADD: carry = carry-out; ovf = two's-complement signed overflow.
REQ-020 SUB: computes a-b; carry = borrow; ovf = signed overflow.
REQ-021 CMP: result = 0; carry, ovf and zero SHALL be set as for SUB a-b.
REQ-022 SHL/SHR: logical shift of a by b[log2(WIDTH)-1:0]; carry = last bit shifted out, 0 if the shift amount is 0.
REQ-023 MUL: unsigned iterative shift-add, one bit per cycle.
REQ-024 DIV: unsigned restoring division, one bit per cycle.
REQ-025 DIV with b=0: quotient = all ones, remainder = a, dz=1.
REQ-026 zero SHALL equal (result==0) for all ops except CMP.
REQ-027 dz SHALL be 0 for all ops except DIV.
REQ-028 ovf SHALL be 0 for all ops other than ADD, SUB and CMP.
REQ-029 Illegal opcode: result = 0, ill = 1, all other flags 0.

Reset
REQ-030 With reset=0 at a rising edge, the block SHALL:
- go to IDLE;
- set result=0, flags=0, busy=0 and done=0;
- clear the captured operands and the iteration counter.
REQ-031 Reset during EXEC SHALL abort the operation with no done pulse.
REQ-032 An accept SHALL NOT occur on an edge where reset=0.

Structure
REQ-033 Package alu_pkg SHALL hold:
- the opcode enumeration;
- the FSM state enumeration;
- flag bit index constants.
REQ-034 The MUL/DIV datapath SHALL be the sub-module alu_muldiv, which has start, op, a, b, busy, done and a 2*WIDTH result; alu_seq holds all single-cycle logic.

Verification (WIDTH=8)
REQ-035 ADD a=0xFF, b=0x01 -> result=0x0000, zero=1, carry=1, ovf=0; done 2 cycles after accept.
REQ-036 SUB a=0x80, b=0x01 -> result=0x007F, ovf=1, carry=0; CMP with the same operands -> result=0x0000, ovf=1, zero=0.
REQ-037 MUL a=0xFF, b=0xFF -> result=0xFE01, done exactly 10 cycles after accept; an active pulse during busy is ignored.
REQ-038 DIV a=0x64, b=0x07 -> result=0x020E. DIV a=0x5A, b=0x00 -> result=0x5AFF, dz=1, done 2 cycles after accept.
REQ-039 reset=0 on the 4th EXEC cycle of a MUL -> busy=0, result=0, no done; an ADD 3+4 after release -> result=0x0007.
REQ-040 Opcode 0xF -> result=0x0000, ill=1, all other flags 0; the next legal opcode -> ill=0.
